// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter state encoding and client count
package arb_pkg;

    localparam int NUM_CLIENTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_2to4.sv
// rtl/decoder_2to4.sv - 2-to-4 one-hot decoder with enable
module decoder_2to4 (
    input  logic [1:0] a,
    input  logic       en,
    output logic [3:0] y
);

    assign y = en ? (4'b0001 << a) : 4'b0000;

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-client round-robin arbiter with hold timeout and turnaround gap
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD);

    state_e        state_q;
    logic [1:0]    gnt_id_q;
    logic [1:0]    last_id_q;
    logic          gnt_valid_q;
    logic          timeout_q;
    logic [CW-1:0] hold_cnt_q;
    logic [1:0]    winner_d;
    logic          hold_last;

    // First requester strictly after the previous winner, wrapping mod 4.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        winner_d  = pick_winner(req, last_id_q);
        hold_last = (hold_cnt_q == CW'(MAX_HOLD - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_id_q    <= 2'd0;
            last_id_q   <= 2'd3;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (|req) begin
                        state_q     <= ST_GRANT;
                        gnt_id_q    <= winner_d;
                        last_id_q   <= winner_d;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // Release takes precedence over the hold limit.
                    if (!req[gnt_id_q]) begin
                        state_q     <= ST_GAP;
                        gnt_valid_q <= 1'b0;
                    end else if (hold_last) begin
                        state_q     <= ST_GAP;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

    decoder_2to4 u_dec (
        .a  (gnt_id_q),
        .en (gnt_valid_q),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - self-checking bench for rr_arbiter_4 (MAX_HOLD 16 and 4 instances)
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       cmp_en;

    logic [3:0] gnt16, gnt4;
    logic [1:0] gnt_id16, gnt_id4;
    logic       gnt_valid16, gnt_valid4;
    logic       timeout16, timeout4;

    int n_pass;
    int n_total;

    rr_arbiter_4 #(.MAX_HOLD(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt16),
        .gnt_id    (gnt_id16),
        .gnt_valid (gnt_valid16),
        .timeout   (timeout16)
    );

    rr_arbiter_4 #(.MAX_HOLD(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt4),
        .gnt_id    (gnt_id4),
        .gnt_valid (gnt_valid4),
        .timeout   (timeout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: owner = client currently holding the grant (-1 none), held = grant cycles
    // completed, ptr = most recent winner. Any ungranted cycle may arbitrate.
    typedef struct packed {
        int   owner;
        int   held;
        int   ptr;
        logic to;
    } m_t;

    m_t m16, m4;

    function automatic m_t step(input m_t m, input logic [3:0] r, input int maxh);
        m_t n;
        n    = m;
        n.to = 1'b0;
        if (m.owner >= 0) begin
            n.held = m.held + 1;
            if (!r[m.owner]) n.owner = -1;
            else if (n.held == maxh) begin
                n.owner = -1;
                n.to    = 1'b1;
            end
        end else if (r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (r[(m.ptr + k) % 4]) begin
                    n.owner = (m.ptr + k) % 4;
                    break;
                end
            end
            n.ptr  = n.owner;
            n.held = 0;
        end
        return n;
    endfunction

    function automatic m_t m_reset();
        m_t m;
        m.owner = -1;
        m.held  = 0;
        m.ptr   = 3;
        m.to    = 1'b0;
        return m;
    endfunction

    function automatic int exp_gnt(input m_t m);
        return (m.owner >= 0) ? (1 << m.owner) : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m16 = m_reset();
            m4  = m_reset();
        end else begin
            m16 = step(m16, req, 16);
            m4  = step(m4, req, 4);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_gnt16", int'(gnt16), exp_gnt(m16));
            chk("model_valid16", int'(gnt_valid16), int'(m16.owner >= 0));
            chk("model_timeout16", int'(timeout16), int'(m16.to));
            if (m16.owner >= 0) chk("model_id16", int'(gnt_id16), m16.owner);
            chk("model_gnt4", int'(gnt4), exp_gnt(m4));
            chk("model_valid4", int'(gnt_valid4), int'(m4.owner >= 0));
            chk("model_timeout4", int'(timeout4), int'(m4.to));
            if (m4.owner >= 0) chk("model_id4", int'(gnt_id4), m4.owner);
        end
    end

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp_a[0:13];
    int exp_t[0:13];
    int run;
    int prev;

    initial begin
        n_pass  = 0;
        n_total = 0;
        cmp_en  = 1'b0;
        req     = 4'b0000;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Idle after reset
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            chk("idle_gnt", int'(gnt16), 0);
            chk("idle_valid", int'(gnt_valid16), 0);
            chk("idle_timeout", int'(timeout16), 0);
        end

        // Single request held three cycles
        req = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("single_gnt16", int'(gnt16), 4);
            chk("single_gnt4", int'(gnt4), 4);
        end
        req = 4'b0000;
        @(posedge clk); #1;
        chk("single_gap", int'(gnt16), 0);
        chk("single_gap_to", int'(timeout16), 0);
        @(posedge clk); #1;
        chk("single_idle", int'(gnt16), 0);

        // Lone client hitting the hold limit
        exp_a = '{2,2,2,2,0,2,2,2,2,0,2,2,2,2};
        exp_t = '{0,0,0,0,1,0,0,0,0,1,0,0,0,0};
        req = 4'b0010;
        for (int j = 0; j < 14; j++) begin
            @(posedge clk); #1;
            chk($sformatf("lone_to_gnt[%0d]", j), int'(gnt4), exp_a[j]);
            chk($sformatf("lone_to_pulse[%0d]", j), int'(timeout4), exp_t[j]);
        end

        // Two clients alternating via timeout
        do_reset();
        exp_a = '{1,1,1,1,0,2,2,2,2,0,1,1,1,1};
        req = 4'b0011;
        for (int j = 0; j < 14; j++) begin
            @(posedge clk); #1;
            chk($sformatf("pair_gnt[%0d]", j), int'(gnt4), exp_a[j]);
            chk($sformatf("pair_to[%0d]", j), int'(timeout4), exp_t[j]);
        end

        // All four requesting, each releasing after two granted cycles
        do_reset();
        exp_a = '{1,1,0,2,2,0,4,4,0,8,8,0,1,1};
        req  = 4'b1111;
        run  = 0;
        prev = -1;
        for (int j = 0; j < 14; j++) begin
            @(posedge clk); #1;
            chk($sformatf("rr_gnt[%0d]", j), int'(gnt16), exp_a[j]);
            if (gnt_valid16) begin
                if (int'(gnt_id16) == prev) run++;
                else begin
                    run  = 1;
                    prev = int'(gnt_id16);
                end
            end else begin
                run  = 0;
                prev = -1;
            end
            req = 4'b1111;
            if (gnt_valid16 && run == 2) req[gnt_id16] = 1'b0;
        end

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 4'b0100;
        @(posedge clk); #1;
        chk("mid_rst_pre", int'(gnt16), 4);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", int'(gnt16), 0);
        chk("mid_rst_valid", int'(gnt_valid16), 0);
        req = 4'b1111;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_gnt", int'(gnt16), 1);
        chk("post_rst_id", int'(gnt_id16), 0);

        // Randomized traffic against the model
        for (int j = 0; j < 3000; j++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
        end

        @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource (bus, memory port, shared peripheral) between up to four clients. It owns the select/enable pair feeding the existing `decoder_2to4` and turns it into a registered one-hot grant vector. A grant is held while its requester keeps `req` high, bounded by a hold timeout. Every grant is followed by a one-cycle turnaround gap.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may be held; legal range 2..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request per client; level, held until done.
- `gnt`  out  4  one-hot grant, `decoder_2to4` output with `a=gnt_id`, `en=gnt_valid`; all zero when no grant.
- `gnt_id`  out  2  index of granted client; valid only when `gnt_valid`=1.
- `gnt_valid`  out  1  a grant is active this cycle.
- `timeout`  out  1  one-cycle pulse: current grant revoked by hold limit.

## Operation
- FSM states and transitions:
  - IDLE: no grant. If `req`≠0, pick the winner and go to GRANT. Otherwise stay.
  - GRANT: winner's grant is active.
    - `req[gnt_id]`=0: go to GAP.
    - `hold_cnt`==`MAX_HOLD`-1 with `req[gnt_id]` still 1: go to GAP and pulse `timeout`.
  - GAP: grant low for exactly one cycle. If `req`≠0, arbitrate and go to GRANT. Otherwise go to IDLE.
- Winner selection: the first set bit of `req` searching upward (mod 4) from `last_id`+1.
- `last_id` update: loaded with the winner on every grant entry.
- `last_id` reset value: 3, so client 0 has top priority after reset.
- Timed-out client: goes to lowest priority. It is regranted after the gap only if no other client requests.
- `hold_cnt`:
  - width ceil(log2(`MAX_HOLD`)).
  - cleared on entry to GRANT; increments each GRANT cycle.
  - does not wrap, because exit happens at `MAX_HOLD`-1.
- Requests from non-granted clients during GRANT or GAP are not latched. Only `req` levels sampled in the arbitration cycle count.
- `gnt_id` and `gnt_valid` are registered. `gnt` is purely combinational from them through the decoder, so it is glitch-free relative to registers.
- Reset values: state=IDLE, `gnt_valid`=0, `gnt_id`=0, `gnt`=0000, `timeout`=0, `hold_cnt`=0, `last_id`=3.

## Timing
- Request to grant latency: `req` seen high at edge N in IDLE or GAP gives `gnt_valid`=1 from edge N onward, visible in cycle N+1.
- Release latency: `req[gnt_id]` low at edge M gives `gnt`=0 after edge M. GAP then lasts one cycle, and the earliest next grant is after edge M+1.
- Maximum grant duration: exactly `MAX_HOLD` cycles.
- `timeout` timing: high during the first GAP cycle only.
- Client dropping and raising `req` inside GAP: treated as a fresh request in that arbitration.
- Reset asserted mid-grant: `gnt` drops immediately (asynchronously). After deassertion the arbiter resumes from IDLE with `last_id`=3.
- Release and timeout on the same edge: release wins, so `timeout` stays 0.
- All four requesting continuously: grant order 0,1,2,3,0,… with one gap cycle between grants.

## Structure
- Shared package `arb_pkg` holds:
  - state encoding constants: `ST_IDLE`=2'd0, `ST_GRANT`=2'd1, `ST_GAP`=2'd2.
  - `NUM_CLIENTS`=4.
- Sub-module: one instance of the existing `decoder_2to4` (`.y(gnt)`, `.a(gnt_id)`, `.en(gnt_valid)`).
- Winner search is a local function; no further sub-modules.

## Test plan
- Reset release, `req`=0000 for 5 cycles: `gnt`=0000, `gnt_valid`=0, `timeout`=0 throughout.
- `req`=0100 raised once, held 3 cycles, then dropped:
  - `gnt`=0100 for 3 cycles starting one cycle after request.
  - then 0000 for one cycle, then IDLE.
- `req`=1111 held for 12 cycles, `MAX_HOLD`=16, each client drops its `req` after 2 granted cycles then re-raises it:
  - grant sequence 0001,0010,0100,1000,0001.
  - each grant 2 cycles, one gap cycle between grants.
- `req`=0010 held permanently, `MAX_HOLD`=4:
  - `gnt`=0010 for exactly 4 cycles, then `timeout`=1 with `gnt`=0000 for one cycle.
  - then `gnt`=0010 again; pattern repeats.
- `req`=0011 held permanently, `MAX_HOLD`=4: client 0 for 4 cycles, timeout, then client 1 for 4 cycles, timeout, then client 0 again.
- `rst` pulsed high during cycle 2 of a grant to client 2:
  - `gnt`=0000 immediately.
  - after release with `req`=1111, first grant goes to client 0.
